// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : Device side of a mode-0 SPI flash link. Decodes READ (0x03),
//            JEDEC ID (0x9F) and READ STATUS (0x05), fetches bytes from a
//            byte-wide synchronous memory port and shifts them out on MISO.
//            SPI pins are oversampled in the single system clock domain.
// Ports    : clock, reset     - system clock, synchronous active-high reset
//            spi_clk/cs/mosi  - SPI master pins (asynchronous to clock)
//            spi_miso         - serial data out, 0 whenever not busy
//            mem_rd/mem_addr  - one-cycle read strobe and its address
//            mem_rdata        - read data, valid one clock after mem_rd
//            busy             - transfer in progress (cs synchronized-low)
//            cmd_err          - one-cycle pulse on an unsupported opcode
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int          ADDR_WIDTH  = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2          // minimum 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam logic [7:0]            c_OP_READ = 8'h03;
  localparam logic [7:0]            c_OP_ID   = 8'h9F;
  localparam logic [7:0]            c_OP_STAT = 8'h05;
  localparam logic [4:0]            c_LAST_BIT_OF_BYTE = 5'd7;
  localparam logic [4:0]            c_LAST_ADDR_BIT    = 5'd23;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_ID     = 3'd4,
    S_STAT   = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_wait_cs_high;
  logic [4:0]             r_bit_cnt;
  logic [23:0]            r_shift_in;
  logic [7:0]             r_tx;
  logic [1:0]             r_id_idx;
  logic                   r_rd_pending;

  logic        w_sclk;
  logic        w_mosi;
  logic        w_cs_act;
  logic        w_rise;
  logic        w_fall;
  logic [23:0] w_shift_next;
  logic [7:0]  w_id_byte;
  logic        w_responding;

  // --------------------------------------------------------------------------
  // Input synchronizers. Reset fills them with zeros, which makes cs look
  // asserted; r_wait_cs_high then blocks any transfer until cs is seen high,
  // so a reset in the middle of a transfer never picks it up half-way.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sclk_sync    <= '0;
      r_cs_sync      <= '0;
      r_mosi_sync    <= '0;
      r_sclk_prev    <= 1'b0;
      r_wait_cs_high <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      if (!w_cs_act) begin
        r_wait_cs_high <= 1'b0;
      end
    end
  end

  assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_act = ~r_cs_sync[SYNC_STAGES-1];

  // Edges are qualified by cs so an edge coincident with deassert is dropped.
  assign w_rise = w_sclk & ~r_sclk_prev & w_cs_act;
  assign w_fall = ~w_sclk & r_sclk_prev & w_cs_act;

  assign w_shift_next = {r_shift_in[22:0], w_mosi};
  assign w_responding = (state_q == S_DATA) || (state_q == S_ID) || (state_q == S_STAT);

  always_comb begin
    w_id_byte = 8'h00;
    case (r_id_idx)
      2'd1:    w_id_byte = JEDEC_ID[15:8];
      2'd2:    w_id_byte = JEDEC_ID[7:0];
      default: w_id_byte = 8'h00;
    endcase
  end

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_cs_act && !r_wait_cs_high) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (w_rise && (r_bit_cnt == c_LAST_BIT_OF_BYTE)) begin
          case (w_shift_next[7:0])
            c_OP_READ: state_d = S_ADDR;
            c_OP_ID:   state_d = S_ID;
            c_OP_STAT: state_d = S_STAT;
            default:   state_d = S_IGNORE;
          endcase
        end
      end
      S_ADDR: begin
        if (w_rise && (r_bit_cnt == c_LAST_ADDR_BIT)) begin
          state_d = S_DATA;
        end
      end
      default: state_d = state_q;
    endcase
    // cs release wins over everything, whatever the state.
    if (!w_cs_act) begin
      state_d = S_IDLE;
    end
  end

  assign busy = (state_q != S_IDLE);

  // --------------------------------------------------------------------------
  // Datapath: bit counting, shift registers, memory strobes and MISO.
  // Byte loads happen on the 8th rising edge (or one clock later for memory
  // data); shifting happens on falling edges, so the two never coincide given
  // the minimum 3-clock SPI half-period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_shift_in   <= '0;
      r_tx         <= '0;
      r_id_idx     <= '0;
      r_rd_pending <= 1'b0;
      spi_miso     <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      cmd_err      <= 1'b0;
    end else begin
      mem_rd       <= 1'b0;
      cmd_err      <= 1'b0;
      r_rd_pending <= mem_rd;

      if ((state_q == S_IDLE) || !w_cs_act) begin
        // Partial bytes are simply dropped.
        r_bit_cnt    <= '0;
        r_shift_in   <= '0;
        r_tx         <= '0;
        r_id_idx     <= '0;
        r_rd_pending <= 1'b0;
        spi_miso     <= 1'b0;
      end else begin
        if (w_rise) begin
          r_shift_in <= w_shift_next;
          case (state_q)
            S_CMD: begin
              if (r_bit_cnt == c_LAST_BIT_OF_BYTE) begin
                r_bit_cnt <= '0;
                case (w_shift_next[7:0])
                  c_OP_READ: r_tx <= 8'h00;
                  c_OP_ID: begin
                    r_tx     <= JEDEC_ID[23:16];
                    r_id_idx <= 2'd1;
                  end
                  c_OP_STAT: r_tx <= 8'h00;
                  default:   cmd_err <= 1'b1;
                endcase
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
            S_ADDR: begin
              if (r_bit_cnt == c_LAST_ADDR_BIT) begin
                r_bit_cnt <= '0;
                mem_rd    <= 1'b1;
                mem_addr  <= w_shift_next[ADDR_WIDTH-1:0];
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
            S_DATA, S_ID, S_STAT: begin
              if (r_bit_cnt == c_LAST_BIT_OF_BYTE) begin
                r_bit_cnt <= '0;
                if (state_q == S_DATA) begin
                  // Prefetch the next byte; wraps modulo 2^ADDR_WIDTH.
                  mem_rd   <= 1'b1;
                  mem_addr <= mem_addr + c_ADDR_ONE;
                end else if (state_q == S_ID) begin
                  r_tx <= w_id_byte;
                  if (r_id_idx != 2'd3) begin
                    r_id_idx <= r_id_idx + 2'd1;
                  end
                end else begin
                  r_tx <= 8'h00;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
            default: r_bit_cnt <= r_bit_cnt;
          endcase
        end

        if (r_rd_pending) begin
          r_tx <= mem_rdata;
        end

        if (w_fall && w_responding) begin
          spi_miso <= r_tx[7];
          r_tx     <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench for spi_flash_responder. A behavioural SPI
//            master drives transactions; a memory model answers reads with
//            mem[a] = a[7:0] ^ key; expected bytes and strobe addresses are
//            computed from the command rules with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam int HALF = 5;  // SPI half-period in system clocks

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        cmd_err;

  logic [7:0]  mem_key = 8'h00;
  int          checks   = 0;
  int          failures = 0;

  // Monitor state, written only by the monitor process.
  logic [23:0] rd_q[$];
  int          err_cycles  = 0;
  int          busy_cycles = 0;
  int          idle_miso   = 0;
  int          rd_consec   = 0;
  logic        prev_rd     = 1'b0;

  logic [7:0]  rx_buf[8];

  spi_flash_responder #(
    .ADDR_WIDTH (24),
    .JEDEC_ID   (24'hEF4016),
    .SYNC_STAGES(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clock = ~clock;

  // Synchronous memory: data for the presented address one clock later.
  always @(posedge clock) mem_rdata <= mem_addr[7:0] ^ mem_key;

  always @(negedge clock) begin
    if (mem_rd) begin
      rd_q.push_back(mem_addr);
      if (prev_rd) rd_consec++;
    end
    prev_rd = mem_rd;
    if (cmd_err) err_cycles++;
    if (busy) busy_cycles++;
    if (!busy && spi_miso) idle_miso++;
  end

  // ---------------------------------------------------------------- helpers
  task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clock);
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clock);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_assert();
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic cs_release();
    repeat (HALF) @(negedge clock);
    spi_cs = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  // Full READ transaction; received bytes land in rx_buf.
  task automatic do_read(input logic [23:0] addr, input int nbytes);
    logic [31:0] r;
    cs_assert();
    spi_bits({8'h03, addr}, 32, r);
    for (int k = 0; k < nbytes; k++) begin
      spi_bits(32'h0, 8, r);
      rx_buf[k] = r[7:0];
    end
    cs_release();
  endtask

  // Reference: byte k of a read at addr, and strobe address k.
  function automatic logic [23:0] ref_addr(input logic [23:0] addr, input int k);
    return addr + 24'(k);  // 24-bit result wraps modulo 2^24
  endfunction

  function automatic logic [7:0] ref_byte(input logic [23:0] addr, input int k, input logic [7:0] key);
    logic [23:0] a;
    a = ref_addr(addr, k);
    return a[7:0] ^ key;
  endfunction

  // Checks bytes and strobes of a read; a read of n bytes strobes n+1 times
  // because the 8th rising edge of the last byte prefetches the next one.
  task automatic check_read(input string name, input logic [23:0] addr, input int nbytes, input int rd_start);
    for (int k = 0; k < nbytes; k++) begin
      checks++;
      if (rx_buf[k] !== ref_byte(addr, k, mem_key)) begin
        failures++;
        $display("FAIL %s byte%0d: got %h expected %h", name, k, rx_buf[k], ref_byte(addr, k, mem_key));
      end
    end
    checks++;
    if (rd_q.size() - rd_start != nbytes + 1) begin
      failures++;
      $display("FAIL %s rd_count: got %0d expected %0d", name, rd_q.size() - rd_start, nbytes + 1);
    end else begin
      for (int k = 0; k <= nbytes; k++) begin
        checks++;
        if (rd_q[rd_start + k] !== ref_addr(addr, k)) begin
          failures++;
          $display("FAIL %s rd_addr%0d: got %h expected %h", name, k, rd_q[rd_start + k], ref_addr(addr, k));
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({spi_miso, mem_rd, mem_addr, busy, cmd_err} !== 28'h0) begin
      failures++;
      $display("FAIL %s: miso=%b rd=%b addr=%h busy=%b err=%b expected all 0",
               name, spi_miso, mem_rd, mem_addr, busy, cmd_err);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    repeat (5) @(negedge clock);
    check_outputs_zero("reset_hold");
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check_outputs_zero("reset_idle");
  endtask

  task automatic test_read();
    int s;
    mem_key = 8'h00;
    s = rd_q.size();
    do_read(24'h000010, 4);
    check_read("read", 24'h000010, 4, s);
  endtask

  task automatic test_jedec();
    logic [31:0] r;
    logic [31:0] exp_id;
    int s, e;
    exp_id = 32'hEF401600;
    s = rd_q.size(); e = err_cycles;
    cs_assert();
    spi_bits(32'h9F, 8, r);
    spi_bits(32'h0, 32, r);
    cs_release();
    checks++;
    if (r !== exp_id) begin
      failures++;
      $display("FAIL jedec_bytes: got %h expected %h", r, exp_id);
    end
    checks++;
    if (rd_q.size() != s || err_cycles != e) begin
      failures++;
      $display("FAIL jedec_side: rd=%0d err=%0d expected 0 0", rd_q.size() - s, err_cycles - e);
    end
  endtask

  task automatic test_wrap();
    int s;
    mem_key = 8'h00;
    s = rd_q.size();
    do_read(24'hFFFFFF, 2);
    check_read("wrap", 24'hFFFFFF, 2, s);
  endtask

  task automatic test_bad_opcode();
    logic [31:0] r;
    logic [7:0]  ops[2];
    int e;
    ops[0] = 8'hAB;
    ops[1] = 8'($urandom_range(0, 255));
    if (ops[1] == 8'h03 || ops[1] == 8'h9F || ops[1] == 8'h05) ops[1] = 8'hC7;
    for (int i = 0; i < 2; i++) begin
      e = err_cycles;
      cs_assert();
      spi_bits({24'h0, ops[i]}, 8, r);
      spi_bits(32'hFFFF, 16, r);
      cs_release();
      checks++;
      if (err_cycles - e != 1) begin
        failures++;
        $display("FAIL bad_op_err %h: got %0d cycles expected 1", ops[i], err_cycles - e);
      end
      checks++;
      if (r[15:0] !== 16'h0) begin
        failures++;
        $display("FAIL bad_op_miso %h: got %h expected 0000", ops[i], r[15:0]);
      end
    end
    e = err_cycles;
    cs_assert();
    spi_bits(32'h05, 8, r);
    spi_bits(32'h0, 16, r);
    cs_release();
    checks++;
    if (r[15:0] !== 16'h0 || err_cycles != e) begin
      failures++;
      $display("FAIL status: got %h err=%0d expected 0000 err=0", r[15:0], err_cycles - e);
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int s;
    s = rd_q.size();
    cs_assert();
    spi_bits(32'h03, 8, r);
    spi_bits(32'hABC, 12, r);
    repeat (HALF) @(negedge clock);
    spi_cs = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || spi_miso !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: busy=%b miso=%b expected 0 0 within 3 clocks", busy, spi_miso);
    end
    repeat (8) @(negedge clock);
    checks++;
    if (rd_q.size() != s) begin
      failures++;
      $display("FAIL abort_rd: got %0d strobes expected 0", rd_q.size() - s);
    end
    mem_key = 8'h00;
    s = rd_q.size();
    do_read(24'h000020, 2);
    check_read("after_abort", 24'h000020, 2, s);
  endtask

  task automatic test_reset_mid_data();
    logic [31:0] r;
    int s, b;
    mem_key = 8'h00;
    cs_assert();
    spi_bits(32'h03000040, 32, r);
    spi_bits(32'h0, 8, r);
    checks++;
    if (r[7:0] !== 8'h40) begin
      failures++;
      $display("FAIL rst_mid_first: got %h expected 40", r[7:0]);
    end
    reset = 1'b1;
    @(negedge clock);
    check_outputs_zero("rst_mid_outputs");
    reset = 1'b0;
    s = rd_q.size(); b = busy_cycles;
    spi_bits(32'h0, 16, r);
    checks++;
    if (r[15:0] !== 16'h0 || busy_cycles != b || rd_q.size() != s) begin
      failures++;
      $display("FAIL rst_mid_quiet: miso=%h busy_cyc=%0d rd=%0d expected 0 0 0",
               r[15:0], busy_cycles - b, rd_q.size() - s);
    end
    cs_release();
    s = rd_q.size();
    do_read(24'h000000, 2);
    check_read("after_reset", 24'h000000, 2, s);
  endtask

  // Back-to-back random reads, some straddling the top of the address space.
  task automatic test_random_reads();
    logic [23:0] a;
    int n, s;
    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom);
      if ($urandom_range(0, 2) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
      n = $urandom_range(1, 4);
      mem_key = 8'($urandom);
      s = rd_q.size();
      do_read(a, n);
      check_read("random_read", a, n, s);
    end
    mem_key = 8'h00;
  endtask

  task automatic test_invariants();
    checks++;
    if (idle_miso != 0) begin
      failures++;
      $display("FAIL idle_miso: got %0d cycles expected 0", idle_miso);
    end
    checks++;
    if (rd_consec != 0) begin
      failures++;
      $display("FAIL rd_consecutive: got %0d expected 0", rd_consec);
    end
  endtask

  initial begin
    reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    @(negedge clock);
    test_reset();
    test_read();
    test_jedec();
    test_wrap();
    test_bad_opcode();
    test_abort();
    test_reset_mid_data();
    test_random_reads();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
